// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: stall/flush FSM, operand forwarding selects and
// saturating stall/flush statistics counters.
module ex_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rs,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        if_id_uses_rt,
  input  logic        ex_mem_reg_write,
  input  logic [4:0]  ex_mem_rd,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_rd,
  input  logic        ex_busy,
  input  logic        branch_taken,
  input  logic        clr_stats,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        id_ex_hold,
  output logic        if_id_flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_load_use;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_events;

  function automatic logic [1:0] fwd_sel(
    input logic       ex_we,
    input logic [4:0] ex_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] src
  );
    if (ex_we && (ex_rd != 5'd0) && (ex_rd == src))
      return 2'b10;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // The instruction in IF/ID is a NOP right after a flush, so its fields are ignored.
  assign w_load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt))) &&
                      (r_state != ST_FLUSH);

  always_comb begin
    w_next_state = ST_RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    if_id_flush  = 1'b0;
    if (ex_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_hold   = 1'b1;
      w_next_state = ST_HOLD;
    end else if (branch_taken) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      w_next_state = ST_FLUSH;
    end else if (w_load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_RUN;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else if (clr_stats) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!pc_write)
        r_stall_cycles <= sat_inc(r_stall_cycles);
      if (if_id_flush)
        r_flush_events <= sat_inc(r_flush_events);
    end
  end

  assign forward_a    = fwd_sel(ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd, id_ex_rs);
  assign forward_b    = fwd_sel(ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd, id_ex_rt);
  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the hazard rules.
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_ex_mem_read = 1'b0;
  logic [4:0]  id_ex_rs = '0, id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic        if_id_uses_rt = 1'b0;
  logic        ex_mem_reg_write = 1'b0;
  logic [4:0]  ex_mem_rd = '0;
  logic        mem_wb_reg_write = 1'b0;
  logic [4:0]  mem_wb_rd = '0;
  logic        ex_busy = 1'b0, branch_taken = 1'b0, clr_stats = 1'b0;
  logic        pc_write, if_id_write, id_ex_bubble, id_ex_hold, if_id_flush;
  logic [1:0]  forward_a, forward_b, state;
  logic [15:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  // model state: 0 RUN, 1 HOLD, 2 FLUSH
  int m_state = 0, m_next = 0;
  int m_stall = 0, m_flush = 0;
  logic e_pc, e_ifw, e_bub, e_hold, e_fl;
  logic [1:0] e_fa, e_fb;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
    .ex_busy(ex_busy), .branch_taken(branch_taken), .clr_stats(clr_stats),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .id_ex_hold(id_ex_hold), .if_id_flush(if_id_flush),
    .forward_a(forward_a), .forward_b(forward_b), .state(state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(logic [4:0] src);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
    if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected combinational outputs and next state from current inputs.
  task automatic model_eval();
    bit lu;
    #1;
    lu = id_ex_mem_read && id_ex_rt != 0 &&
         (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt)) &&
         m_state != 2;
    {e_pc, e_ifw, e_bub, e_hold, e_fl} = 5'b11000;
    m_next = 0;
    if (ex_busy) begin
      {e_pc, e_ifw, e_bub, e_hold, e_fl} = 5'b00010; m_next = 1;
    end else if (branch_taken) begin
      {e_pc, e_ifw, e_bub, e_hold, e_fl} = 5'b11101; m_next = 2;
    end else if (lu) begin
      {e_pc, e_ifw, e_bub, e_hold, e_fl} = 5'b00100;
    end
    e_fa = ref_fwd(id_ex_rs);
    e_fb = ref_fwd(id_ex_rt);
  endtask

  task automatic model_clock();
    model_eval();
    @(posedge clk);
    if (clr_stats) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < 65535) m_stall++;
      if (e_fl && m_flush < 65535) m_flush++;
    end
    m_state = m_next;
    #1;
  endtask

  task automatic clear_inputs();
    id_ex_mem_read = 0; id_ex_rs = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
    if_id_uses_rt = 0; ex_mem_reg_write = 0; ex_mem_rd = 0; mem_wb_reg_write = 0;
    mem_wb_rd = 0; ex_busy = 0; branch_taken = 0; clr_stats = 0;
  endtask

  task automatic clear_stats();
    clear_inputs(); clr_stats = 1; model_clock(); clr_stats = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, id_ex_hold, if_id_flush, forward_a, forward_b, state} !== 11'b11000000000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {pc_write, if_id_write, id_ex_bubble, id_ex_hold, if_id_flush, forward_a, forward_b, state}, 11'b11000000000);
    end
    checks++;
    if (stall_cycles !== 16'd0 || flush_events !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_events);
    end
    @(posedge clk); #2;
    reset = 0;
    m_state = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    clear_stats();
    id_ex_mem_read = 1; id_ex_rt = 5; if_id_rs = 5;
    model_eval();
    checks++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_write !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall got=pc%b bub%b ifw%b exp=pc0 bub1 ifw0", pc_write, id_ex_bubble, if_id_write);
    end
    model_clock();
    id_ex_mem_read = 0;  // bubble now in ID/EX
    model_eval();
    checks++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL load_use_one_cycle got=pc%b bub%b exp=pc1 bub0", pc_write, id_ex_bubble);
    end
    checks++;
    if (stall_cycles !== 16'd1 || state !== 2'b00) begin
      errors++;
      $display("FAIL load_use_count got=%0d st=%b exp=1 st=00", stall_cycles, state);
    end
    model_clock();
  endtask

  task automatic test_no_false_hazard();
    clear_inputs();
    id_ex_mem_read = 1; id_ex_rt = 0; if_id_rs = 0;
    model_eval();
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL zero_reg_hazard got=%b exp=1", pc_write);
    end
    id_ex_rt = 9; if_id_rs = 3; if_id_rt = 9; if_id_uses_rt = 0;
    model_eval();
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL rt_unused_hazard got=%b exp=1", pc_write);
    end
    if_id_uses_rt = 1;
    model_eval();
    checks++;
    if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1) begin
      errors++; $display("FAIL rt_used_hazard got=pc%b bub%b exp=pc0 bub1", pc_write, id_ex_bubble);
    end
    clear_inputs();
    model_clock();
  endtask

  task automatic test_busy();
    clear_stats();
    ex_busy = 1;
    for (int i = 0; i < 3; i++) begin
      model_eval();
      checks++;
      if (id_ex_hold !== 1'b1 || pc_write !== 1'b0 || id_ex_bubble !== 1'b0 || if_id_flush !== 1'b0) begin
        errors++;
        $display("FAIL busy_outputs cyc%0d got=hold%b pc%b bub%b fl%b exp=hold1 pc0 bub0 fl0", i, id_ex_hold, pc_write, id_ex_bubble, if_id_flush);
      end
      model_clock();
      checks++;
      if (state !== 2'b01) begin
        errors++; $display("FAIL busy_state cyc%0d got=%b exp=01", i, state);
      end
    end
    ex_busy = 0;
    model_eval();
    checks++;
    if (pc_write !== 1'b1 || id_ex_hold !== 1'b0) begin
      errors++; $display("FAIL busy_release got=pc%b hold%b exp=pc1 hold0", pc_write, id_ex_hold);
    end
    model_clock();
    checks++;
    if (state !== 2'b00 || stall_cycles !== 16'd3) begin
      errors++; $display("FAIL busy_after got=st%b stall%0d exp=st00 stall3", state, stall_cycles);
    end
  endtask

  task automatic test_branch();
    clear_stats();
    branch_taken = 1; id_ex_mem_read = 1; id_ex_rt = 4; if_id_rs = 4;
    model_eval();
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_hold} !== 5'b11110) begin
      errors++;
      $display("FAIL branch_outputs got=%b exp=11110", {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_hold});
    end
    model_clock();
    checks++;
    if (state !== 2'b10 || flush_events !== 16'd1) begin
      errors++; $display("FAIL branch_state got=st%b fl%0d exp=st10 fl1", state, flush_events);
    end
    branch_taken = 0;
    model_eval();
    checks++;
    if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
      errors++; $display("FAIL flush_suppress got=pc%b bub%b exp=pc1 bub0", pc_write, id_ex_bubble);
    end
    model_clock();
    model_eval();
    checks++;
    if (state !== 2'b00 || pc_write !== 1'b0) begin
      errors++; $display("FAIL after_flush got=st%b pc%b exp=st00 pc0", state, pc_write);
    end
    clear_inputs();
    model_clock();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    ex_mem_rd = 7; mem_wb_rd = 7; id_ex_rs = 7; id_ex_rt = 2;
    ex_mem_reg_write = 1; mem_wb_reg_write = 1;
    model_eval();
    checks++;
    if (forward_a !== 2'b10 || forward_b !== 2'b00) begin
      errors++; $display("FAIL fwd_exmem got=%b/%b exp=10/00", forward_a, forward_b);
    end
    ex_mem_reg_write = 0;
    model_eval();
    checks++;
    if (forward_a !== 2'b01) begin
      errors++; $display("FAIL fwd_memwb got=%b exp=01", forward_a);
    end
    ex_mem_reg_write = 1; ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs = 0;
    model_eval();
    checks++;
    if (forward_a !== 2'b00) begin
      errors++; $display("FAIL fwd_zero got=%b exp=00", forward_a);
    end
    id_ex_rs = 3; id_ex_rt = 3; ex_mem_rd = 3; mem_wb_rd = 3; ex_mem_reg_write = 0;
    model_eval();
    checks++;
    if (forward_a !== 2'b01 || forward_b !== 2'b01) begin
      errors++; $display("FAIL fwd_b got=%b/%b exp=01/01", forward_a, forward_b);
    end
    clear_inputs();
    model_clock();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      id_ex_mem_read = $urandom_range(0, 1);
      id_ex_rs = 5'($urandom_range(0, 3)); id_ex_rt = 5'($urandom_range(0, 3));
      if_id_rs = 5'($urandom_range(0, 3)); if_id_rt = 5'($urandom_range(0, 3));
      if_id_uses_rt = $urandom_range(0, 1);
      ex_mem_reg_write = $urandom_range(0, 1); ex_mem_rd = 5'($urandom_range(0, 3));
      mem_wb_reg_write = $urandom_range(0, 1); mem_wb_rd = 5'($urandom_range(0, 3));
      ex_busy = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      clr_stats = ($urandom_range(0, 31) == 0);
      model_eval();
      checks++;
      if ({pc_write, if_id_write, id_ex_bubble, id_ex_hold, if_id_flush, forward_a, forward_b} !==
          {e_pc, e_ifw, e_bub, e_hold, e_fl, e_fa, e_fb}) begin
        errors++;
        $display("FAIL rand_outputs cyc%0d got=%b exp=%b", i,
                 {pc_write, if_id_write, id_ex_bubble, id_ex_hold, if_id_flush, forward_a, forward_b},
                 {e_pc, e_ifw, e_bub, e_hold, e_fl, e_fa, e_fb});
      end
      model_clock();
      checks++;
      if (state !== 2'(m_state) || stall_cycles !== 16'(m_stall) || flush_events !== 16'(m_flush)) begin
        errors++;
        $display("FAIL rand_state cyc%0d got=st%b %0d/%0d exp=st%0d %0d/%0d", i, state, stall_cycles, flush_events, m_state, m_stall, m_flush);
      end
    end
    clear_inputs();
    model_clock();
  endtask

  task automatic test_saturation_and_reset();
    clear_stats();
    ex_busy = 1;
    for (int i = 0; i < 65535; i++) model_clock();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_preload got=%h exp=ffff", stall_cycles);
    end
    model_clock();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles);
    end
    ex_busy = 0; clr_stats = 1;
    model_clock();
    clr_stats = 0;
    checks++;
    if (stall_cycles !== 16'd0) begin
      errors++; $display("FAIL clr_stats got=%h exp=0000", stall_cycles);
    end
    ex_busy = 1;
    model_clock();
    checks++;
    if (state !== 2'b01) begin
      errors++; $display("FAIL pre_reset_hold got=%b exp=01", state);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (state !== 2'b00 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL async_reset got=st%b stall%0d exp=st00 stall0", state, stall_cycles);
    end
    m_state = 0; m_stall = 0; m_flush = 0;
    ex_busy = 0;
    @(posedge clk); #2;
    reset = 0;
    @(posedge clk); #1;
    model_eval();
    checks++;
    if (pc_write !== 1'b1 || id_ex_hold !== 1'b0 || if_id_flush !== 1'b0) begin
      errors++; $display("FAIL post_reset got=pc%b hold%b fl%b exp=pc1 hold0 fl0", pc_write, id_ex_hold, if_id_flush);
    end
    model_clock();
    checks++;
    if (state !== 2'b00 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL post_reset_state got=st%b stall%0d exp=st00 stall0", state, stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_busy();
    test_branch();
    test_forwarding();
    test_random();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
